airlock_sequencer: RTL
======================

Name: airlock_sequencer

Overview:
Hardware sequencer for the bathysphere airlock chamber. It sits between the soft processor's PIO lines and the chamber actuators. It runs fill, drain and wait operations with a timed water-level model and a four-phase req/done handshake per operation. It enforces door interlocks: the inner door opens only when the chamber is drained, and the outer door opens only when it is full.

Parameters:
LEVEL_MAX, 7, full-chamber level; level 0 = drained
LEVEL_W, 3, width of level output; must hold LEVEL_MAX
STEP_CYCLES, 5000000, clock cycles per one-level change (0.1 s at 50 MHz)
WAIT_CYCLES, 50000000, duration of a wait operation (1 s at 50 MHz)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous, active-high reset
fill_req  in  1  fill request, level-held until fill_done
drain_req  in  1  drain request, level-held until drain_done
wait_req  in  1  wait request, level-held until wait_done
inner_door_req  in  1  inner door switch; high = open requested
outer_door_req  in  1  outer door switch; high = open requested
filling  out  1  high while in FILL
draining  out  1  high while in DRAIN
waiting  out  1  high while in WAIT
fill_done  out  1  fill handshake acknowledge
drain_done  out  1  drain handshake acknowledge
wait_done  out  1  wait handshake acknowledge
inner_door_open  out  1  inner door actuator
outer_door_open  out  1  outer door actuator
level  out  LEVEL_W  current chamber water level

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset: state IDLE; level=0; step and wait counters 0; every output 0.
- States: IDLE, FILL, DRAIN, WAIT, DONE_FILL, DONE_DRAIN, DONE_WAIT.
- IDLE accepts an operation only when both doors are closed. Priority is drain > fill > wait. Requests blocked by an open door stay pending; no error is raised.
- Acceptance at edge t puts the block in the op state at t+1, and the busy output (filling/draining/waiting) is high from t+1.
- FILL: the step counter counts 0..STEP_CYCLES-1. On the terminal count, level increments and the counter clears. When that increment makes level==LEVEL_MAX, the block enters DONE_FILL on the same edge, so fill_done and the new level appear in the same cycle.
- Fill accepted with level==LEVEL_MAX goes straight to DONE_FILL.
- DRAIN mirrors FILL: level decrements and completes at 0. Drain accepted with level==0 goes straight to DONE_DRAIN.
- WAIT: counts WAIT_CYCLES cycles; on the last one enters DONE_WAIT. Level is unchanged.
- DONE_x: the matching done stays high while its req is high. When req is low, the block returns to IDLE next edge and done drops.
- A req dropped mid-operation is ignored. The operation completes, done is high for exactly one cycle, then the block returns to IDLE.
- Requests other than the active one are ignored during FILL, DRAIN, WAIT and DONE_x.
- Doors are evaluated only in IDLE:
  - inner_door_open is set when inner_door_req=1, level==0 and outer_door_open=0.
  - outer_door_open is set when outer_door_req=1, level==LEVEL_MAX and inner_door_open=0.
  - A door clears the edge after its req drops.
  - If both door reqs rise in the same cycle, inner wins only if level==0 and outer only if level==LEVEL_MAX, so they never conflict.
  - The two door outputs are never both 1.
- Reset mid-operation returns to the reset state immediately; level returns to 0.

Optional Feature:
AIRLOCK_ABORT_EN:
- Adds input abort_req and output abort_ack.
- In FILL, DRAIN or WAIT, abort_req=1 returns the block to IDLE next edge. Level is frozen at its current value, the counters clear, and no done is asserted. abort_ack pulses for exactly one cycle.
- abort_req in other states is ignored.
- Without the macro, neither port exists and operations always complete.

Decomposition:
- Package airlock_pkg holds the state enum type, the operation-select encoding (NONE/FILL/DRAIN/WAIT) and the priority function.
- One sub-module, airlock_step_timer: a parameterised counter with enable, clear and terminal-count tick. It is instantiated twice, once for the level step and once for the wait duration.

Test Plan:
Bench uses LEVEL_MAX=3, STEP_CYCLES=4, WAIT_CYCLES=10.
- Reset, then fill_req=1 held: filling=1 from the cycle after acceptance; level goes 1,2,3 at 4-cycle intervals; fill_done=1 together with level=3. fill_req=0 → fill_done=0 and IDLE next edge.
- Level=3, drain_req pulsed high for 1 cycle: draining for 12 cycles, level reaches 0, drain_done high for exactly 1 cycle, then IDLE.
- fill_req and drain_req rise together at level=3: drain is chosen; filling never asserts.
- Level=0 with inner_door_req=1 → inner_door_open=1. Then fill_req=1 → no filling while the door is open. Drop inner_door_req → door closes, fill starts the next cycle.
- Level=0 with outer_door_req=1 → outer_door_open stays 0. After a fill to level 3 → outer_door_open=1.
- Macro on: abort_req at level=2 during FILL → IDLE next edge, level holds 2, abort_ack one cycle, fill_done never asserts.

Source files
------------

// File: rtl/airlock_pkg.sv
// Shared types for the airlock sequencer: state encoding, operation select
// and the request priority function.
package airlock_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE       = 3'd0;
   localparam state_t ST_FILL       = 3'd1;
   localparam state_t ST_DRAIN      = 3'd2;
   localparam state_t ST_WAIT       = 3'd3;
   localparam state_t ST_DONE_FILL  = 3'd4;
   localparam state_t ST_DONE_DRAIN = 3'd5;
   localparam state_t ST_DONE_WAIT  = 3'd6;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_FILL  = 2'd1,
      OP_DRAIN = 2'd2,
      OP_WAIT  = 2'd3
   } op_sel_t;

   // Drain beats fill beats wait.
   function automatic op_sel_t op_select(input logic fill_req,
                                         input logic drain_req,
                                         input logic wt_req);
      if (drain_req)     return OP_DRAIN;
      else if (fill_req) return OP_FILL;
      else if (wt_req)   return OP_WAIT;
      else               return OP_NONE;
   endfunction

endpackage

// File: rtl/airlock_step_timer.sv
// Free-running cycle counter with enable and clear; tick is high on the
// last enabled cycle of each CYCLES-long period.
module airlock_step_timer #(
   parameter int CYCLES = 4,
   parameter int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr || tick) cnt_d = '0;
      else if (en)     cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: fill/drain/wait with req/done handshakes and
// door interlocks. Define AIRLOCK_ABORT_EN to add abort_req/abort_ack.
module airlock_sequencer #(
   parameter int LEVEL_MAX   = 7,
   parameter int LEVEL_W     = 3,
   parameter int STEP_CYCLES = 5000000,
   parameter int WAIT_CYCLES = 50000000
) (
   input  logic               clk_clk,
   input  logic               reset_reset,
   input  logic               fill_req,
   input  logic               drain_req,
   input  logic               wait_req,
   input  logic               inner_door_req,
   input  logic               outer_door_req,
   output logic               filling,
   output logic               draining,
   output logic               waiting,
   output logic               fill_done,
   output logic               drain_done,
   output logic               wait_done,
   output logic               inner_door_open,
   output logic               outer_door_open,
`ifdef AIRLOCK_ABORT_EN
   input  logic               abort_req,
   output logic               abort_ack,
`endif
   output logic [LEVEL_W-1:0] level
);

   import airlock_pkg::*;

   localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(LEVEL_MAX);
   localparam logic [LEVEL_W-1:0] LVL_PRE = LEVEL_W'(LEVEL_MAX - 1);

   state_t               state_q, state_d;
   logic [LEVEL_W-1:0]   level_q, level_d;
   logic                 filling_q, filling_d;
   logic                 draining_q, draining_d;
   logic                 waiting_q, waiting_d;
   logic                 fill_done_q, fill_done_d;
   logic                 drain_done_q, drain_done_d;
   logic                 wait_done_q, wait_done_d;
   logic                 inner_q, inner_d;
   logic                 outer_q, outer_d;
   logic                 step_tick, wait_tick;
   logic                 busy, abort_hit, doors_closed, idle_stay;
   op_sel_t              op;

   assign busy         = (state_q == ST_FILL) || (state_q == ST_DRAIN) || (state_q == ST_WAIT);
   assign doors_closed = !inner_q && !outer_q;
   assign op           = op_select(fill_req, drain_req, wait_req);

`ifdef AIRLOCK_ABORT_EN
   logic abort_ack_q;
   assign abort_hit = abort_req && busy;
   assign abort_ack = abort_ack_q;
   always_ff @(posedge clk_clk) begin
      if (reset_reset) abort_ack_q <= 1'b0;
      else             abort_ack_q <= abort_hit;
   end
`else
   assign abort_hit = 1'b0;
`endif

   airlock_step_timer #(.CYCLES(STEP_CYCLES)) u_step_timer (
      .clk  (clk_clk),
      .rst  (reset_reset),
      .en   ((state_q == ST_FILL) || (state_q == ST_DRAIN)),
      .clr  (abort_hit),
      .tick (step_tick)
   );

   airlock_step_timer #(.CYCLES(WAIT_CYCLES)) u_wait_timer (
      .clk  (clk_clk),
      .rst  (reset_reset),
      .en   (state_q == ST_WAIT),
      .clr  (abort_hit),
      .tick (wait_tick)
   );

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      case (state_q)
         ST_IDLE: begin
            if (doors_closed) begin
               case (op)
                  OP_DRAIN: state_d = (level_q == '0)     ? ST_DONE_DRAIN : ST_DRAIN;
                  OP_FILL:  state_d = (level_q == LVL_MAX) ? ST_DONE_FILL  : ST_FILL;
                  OP_WAIT:  state_d = ST_WAIT;
                  default:  state_d = ST_IDLE;
               endcase
            end
         end
         ST_FILL: begin
            if (abort_hit) state_d = ST_IDLE;
            else if (step_tick) begin
               level_d = level_q + 1'b1;
               if (level_q == LVL_PRE) state_d = ST_DONE_FILL;
            end
         end
         ST_DRAIN: begin
            if (abort_hit) state_d = ST_IDLE;
            else if (step_tick) begin
               level_d = level_q - 1'b1;
               if (level_q == LEVEL_W'(1)) state_d = ST_DONE_DRAIN;
            end
         end
         ST_WAIT: begin
            if (abort_hit)      state_d = ST_IDLE;
            else if (wait_tick) state_d = ST_DONE_WAIT;
         end
         ST_DONE_FILL:  if (!fill_req)  state_d = ST_IDLE;
         ST_DONE_DRAIN: if (!drain_req) state_d = ST_IDLE;
         ST_DONE_WAIT:  if (!wait_req)  state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase

      // Doors only open while the block stays idle, so an accepted op and a
      // door opening can never coincide.
      idle_stay = (state_q == ST_IDLE) && (state_d == ST_IDLE);
      inner_d   = inner_q;
      outer_d   = outer_q;
      if (!inner_door_req) inner_d = 1'b0;
      else if (idle_stay && (level_q == '0) && !outer_q) inner_d = 1'b1;
      if (!outer_door_req) outer_d = 1'b0;
      else if (idle_stay && (level_q == LVL_MAX) && !inner_q) outer_d = 1'b1;

      filling_d    = (state_d == ST_FILL);
      draining_d   = (state_d == ST_DRAIN);
      waiting_d    = (state_d == ST_WAIT);
      fill_done_d  = (state_d == ST_DONE_FILL);
      drain_done_d = (state_d == ST_DONE_DRAIN);
      wait_done_d  = (state_d == ST_DONE_WAIT);
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q      <= ST_IDLE;
         level_q      <= '0;
         filling_q    <= 1'b0;
         draining_q   <= 1'b0;
         waiting_q    <= 1'b0;
         fill_done_q  <= 1'b0;
         drain_done_q <= 1'b0;
         wait_done_q  <= 1'b0;
         inner_q      <= 1'b0;
         outer_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         filling_q    <= filling_d;
         draining_q   <= draining_d;
         waiting_q    <= waiting_d;
         fill_done_q  <= fill_done_d;
         drain_done_q <= drain_done_d;
         wait_done_q  <= wait_done_d;
         inner_q      <= inner_d;
         outer_q      <= outer_d;
      end
   end

   assign filling         = filling_q;
   assign draining        = draining_q;
   assign waiting         = waiting_q;
   assign fill_done       = fill_done_q;
   assign drain_done      = drain_done_q;
   assign wait_done       = wait_done_q;
   assign inner_door_open = inner_q;
   assign outer_door_open = outer_q;
   assign level           = level_q;

endmodule
